// File: rtl/tc_add_arb.sv
// rtl/tc_add_arb.sv - round-robin arbiter sharing one FP adder pipe, with in-order ID FIFO response steering
// Optional perf counters (perf_issue_o, perf_stall_o) when TC_ADD_ARB_PERF_EN is defined.
module tc_add_arb #(
   parameter int NUM_REQ    = 4,
   parameter int IDW        = 2,
   parameter int EXPWIDTH   = 5,
   parameter int PRECISION  = 11,
   parameter int FIFO_DEPTH = 4,
   localparam int FW        = EXPWIDTH + PRECISION
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic [NUM_REQ*FW-1:0] req_a_i,
   input  logic [NUM_REQ*FW-1:0] req_b_i,
   input  logic [NUM_REQ*3-1:0] req_rm_i,
   output logic                 pipe_in_valid_o,
   input  logic                 pipe_in_ready_i,
   output logic [FW-1:0]        pipe_a_o,
   output logic [FW-1:0]        pipe_b_o,
   output logic [2:0]           pipe_rm_o,
   input  logic                 pipe_out_valid_i,
   output logic                 pipe_out_ready_o,
   input  logic [FW-1:0]        pipe_result_i,
   input  logic [4:0]           pipe_fflags_i,
   output logic [NUM_REQ-1:0]   rsp_valid_o,
   input  logic [NUM_REQ-1:0]   rsp_ready_i,
   output logic [FW-1:0]        rsp_result_o,
   output logic [4:0]           rsp_fflags_o,
`ifdef TC_ADD_ARB_PERF_EN
   output logic [31:0]          perf_issue_o,
   output logic [31:0]          perf_stall_o,
`endif
   output logic                 err_o
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     gnt_idx;
   logic [IDW-1:0]     head;
   logic [IDW-1:0]     id_mem [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [PW:0]        count;
   logic [NUM_REQ-1:0] gnt_oh;
   logic [NUM_REQ-1:0] head_oh;
   logic               any_valid;
   logic               gnt_active;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;

   assign any_valid  = |req_valid_i;
   assign gnt_active = rst_n && any_valid;
   assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);

   // Cyclic search starting just after the last winner.
   always_comb begin
      int             cand;
      logic           found;
      logic [IDW-1:0] cand_idx;
      cand     = 0;
      cand_idx = '0;
      found    = 1'b0;
      gnt_idx  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand     = (int'(rr_ptr) + k) % NUM_REQ;
         cand_idx = IDW'(cand);
         if (!found && req_valid_i[cand_idx]) begin
            found   = 1'b1;
            gnt_idx = cand_idx;
         end
      end
   end

   assign gnt_oh          = NUM_REQ'(1) << gnt_idx;
   assign pipe_in_valid_o = gnt_active && !fifo_full;
   assign req_ready_o     = (gnt_active && pipe_in_ready_i && !fifo_full) ? gnt_oh : '0;
   assign pipe_a_o        = gnt_active ? req_a_i[int'(gnt_idx)*FW +: FW] : '0;
   assign pipe_b_o        = gnt_active ? req_b_i[int'(gnt_idx)*FW +: FW] : '0;
   assign pipe_rm_o       = gnt_active ? req_rm_i[int'(gnt_idx)*3 +: 3] : '0;

   assign head             = id_mem[rd_ptr];
   assign head_oh          = NUM_REQ'(1) << head;
   assign rsp_valid_o      = (rst_n && pipe_out_valid_i && !fifo_empty) ? head_oh : '0;
   assign pipe_out_ready_o = rst_n && !fifo_empty && rsp_ready_i[head];
   assign rsp_result_o     = pipe_result_i;
   assign rsp_fflags_o     = pipe_fflags_i;

   assign push = pipe_in_valid_o && pipe_in_ready_i;
   assign pop  = pipe_out_valid_i && pipe_out_ready_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= IDW'(NUM_REQ-1);
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         err_o  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) id_mem[i] <= '0;
      end else begin
         if (push) begin
            id_mem[wr_ptr] <= gnt_idx;
            wr_ptr         <= wr_ptr + PW'(1);
            rr_ptr         <= gnt_idx;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);
         // A result with no owner is dropped and flagged until reset.
         if (pipe_out_valid_i && fifo_empty) err_o <= 1'b1;
      end
   end

`ifdef TC_ADD_ARB_PERF_EN
   logic stall;
   assign stall = any_valid && !(pipe_in_ready_i && !fifo_full);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_issue_o <= '0;
         perf_stall_o <= '0;
      end else begin
         if (push && perf_issue_o != 32'hFFFF_FFFF)  perf_issue_o <= perf_issue_o + 32'd1;
         if (stall && perf_stall_o != 32'hFFFF_FFFF) perf_stall_o <= perf_stall_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tc_add_arb.sv
// tb/tb_tc_add_arb.sv - self-checking bench for tc_add_arb against a queue-based reference model
module tb_tc_add_arb;
   localparam int NUM_REQ = 4;
   localparam int DEPTH   = 4;
   localparam int FW      = 16;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
   logic [NUM_REQ*FW-1:0] req_a_i, req_b_i;
   logic [NUM_REQ*3-1:0]  req_rm_i;
   logic                  pipe_in_valid_o, pipe_in_ready_i, pipe_out_valid_i, pipe_out_ready_o, err_o;
   logic [FW-1:0]         pipe_a_o, pipe_b_o, pipe_result_i, rsp_result_o;
   logic [2:0]            pipe_rm_o;
   logic [4:0]            pipe_fflags_i, rsp_fflags_o;
`ifdef TC_ADD_ARB_PERF_EN
   logic [31:0]           perf_issue_o, perf_stall_o;
`endif

   tc_add_arb #(.NUM_REQ(NUM_REQ), .IDW(2), .EXPWIDTH(5), .PRECISION(11), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rm_i(req_rm_i),
      .pipe_in_valid_o(pipe_in_valid_o), .pipe_in_ready_i(pipe_in_ready_i),
      .pipe_a_o(pipe_a_o), .pipe_b_o(pipe_b_o), .pipe_rm_o(pipe_rm_o),
      .pipe_out_valid_i(pipe_out_valid_i), .pipe_out_ready_o(pipe_out_ready_o),
      .pipe_result_i(pipe_result_i), .pipe_fflags_i(pipe_fflags_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_fflags_o(rsp_fflags_o),
`ifdef TC_ADD_ARB_PERF_EN
      .perf_issue_o(perf_issue_o), .perf_stall_o(perf_stall_o),
`endif
      .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int            owner;
      logic [FW-1:0] res;
      logic [4:0]    ff;
   } ent_t;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            rem [NUM_REQ];
   logic [FW-1:0] av [NUM_REQ];
   logic [FW-1:0] bv [NUM_REQ];
   logic [2:0]    rmv [NUM_REQ];
   int            last;
   bit            exp_err;
   int            exp_issue, exp_stall;
   ent_t          q[$];
   int            grant_log[$];
   int            rsp_log[$];
   logic [FW-1:0] rsp_res_log[$];
   bit            out_en, inject_err, use_next;
   logic [FW-1:0] next_res;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic int log_at(input int idx, input int which);
      if (which == 0) return (idx < grant_log.size()) ? grant_log[idx] : -1;
      return (idx < rsp_log.size()) ? rsp_log[idx] : -1;
   endfunction

   task automatic new_op(input int i);
      av[i]  = FW'($urandom);
      bv[i]  = FW'($urandom);
      rmv[i] = 3'($urandom_range(0, 4));
   endtask

   // Requesters and a stub adder pipe that returns queued results in issue order.
   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid_i[i]           = (rem[i] > 0);
         req_a_i[i*FW +: FW]      = av[i];
         req_b_i[i*FW +: FW]      = bv[i];
         req_rm_i[i*3 +: 3]       = rmv[i];
      end
      pipe_out_valid_i = inject_err || (out_en && q.size() > 0);
      if (q.size() > 0) begin
         pipe_result_i = q[0].res;
         pipe_fflags_i = q[0].ff;
      end else begin
         pipe_result_i = FW'($urandom);
         pipe_fflags_i = '0;
      end
   endtask

   task automatic tick();
      int                 g;
      bit                 any, full, found, issue, pop, stall, e_pr;
      logic [NUM_REQ-1:0] e_rv;
      drive();
      @(negedge clk);
      any = 0;
      for (int i = 0; i < NUM_REQ; i++) any |= (rem[i] > 0);
      full  = (q.size() == DEPTH);
      g     = 0;
      found = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int c;
         c = (last + k) % NUM_REQ;
         if (!found && rem[c] > 0) begin
            found = 1;
            g     = c;
         end
      end
      e_pr = (q.size() > 0) && rsp_ready_i[q[0].owner];
      e_rv = (pipe_out_valid_i && q.size() > 0) ? NUM_REQ'(1 << q[0].owner) : '0;
      chk("pipe_in_valid", pipe_in_valid_o, any && !full);
      chk("req_ready", req_ready_o, (any && pipe_in_ready_i && !full) ? NUM_REQ'(1 << g) : '0);
      chk("pipe_a", pipe_a_o, any ? av[g] : '0);
      chk("pipe_b", pipe_b_o, any ? bv[g] : '0);
      chk("pipe_rm", pipe_rm_o, any ? rmv[g] : '0);
      chk("rsp_valid", rsp_valid_o, e_rv);
      chk("pipe_out_ready", pipe_out_ready_o, e_pr);
      chk("rsp_result", rsp_result_o, pipe_result_i);
      chk("rsp_fflags", rsp_fflags_o, pipe_fflags_i);
      chk("err", err_o, exp_err);
      if (req_ready_o != '0 && pipe_in_ready_i) grant_log.push_back(onehot_idx(req_ready_o));
      if ((rsp_valid_o & rsp_ready_i) != '0) begin
         rsp_log.push_back(onehot_idx(rsp_valid_o));
         rsp_res_log.push_back(rsp_result_o);
      end
      issue = any && !full && pipe_in_ready_i;
      pop   = pipe_out_valid_i && e_pr;
      stall = any && !(pipe_in_ready_i && !full);
      if (pipe_out_valid_i && q.size() == 0) exp_err = 1;
      if (pop) void'(q.pop_front());
      if (issue) begin
         ent_t e;
         e.owner = g;
         e.res   = use_next ? next_res : FW'($urandom);
         e.ff    = use_next ? 5'd0 : 5'($urandom);
         q.push_back(e);
         rem[g]--;
         new_op(g);
         last = g;
         exp_issue++;
         use_next = 0;
      end
      if (stall) exp_stall++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      grant_log.delete();
      rsp_log.delete();
      rsp_res_log.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready_o, '0);
      chk({tag, "_pipe_in_valid"}, pipe_in_valid_o, 0);
      chk({tag, "_pipe_a"}, pipe_a_o, '0);
      chk({tag, "_pipe_out_ready"}, pipe_out_ready_o, 0);
      chk({tag, "_rsp_valid"}, rsp_valid_o, '0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   initial begin
      rst_n = 0; pipe_in_ready_i = 1; rsp_ready_i = '1; out_en = 1; inject_err = 0;
      use_next = 0; next_res = '0; last = NUM_REQ-1; exp_err = 0; exp_issue = 0; exp_stall = 0;
      for (int i = 0; i < NUM_REQ; i++) begin rem[i] = 1; new_op(i); end
      drive();
      #12;
      chk_reset_outputs("reset");
      for (int i = 0; i < NUM_REQ; i++) rem[i] = 0;
      drive();
      @(posedge clk); #2 rst_n = 1;
      @(posedge clk); #1;

      // Round-robin with everyone requesting
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) rem[i] = 2;
      repeat (8) tick();
      chk("rr_count", grant_log.size(), 8);
      for (int k = 0; k < 8; k++) chk("rr_order", log_at(k, 0), k % 4);
      repeat (3) tick();
      for (int k = 0; k < 8; k++) chk("rr_rsp_order", log_at(k, 1), k % 4);

      // Pipe backpressure: grant parked on requester 0
      clear_logs();
      rem[0] = 1; rem[3] = 1; pipe_in_ready_i = 0;
      repeat (3) begin
         tick();
         chk("bp_hold_a", pipe_a_o, av[0]);
         chk("bp_no_ready", req_ready_o, '0);
      end
      pipe_in_ready_i = 1;
      repeat (2) tick();
      chk("bp_first", log_at(0, 0), 0);
      chk("bp_second", log_at(1, 0), 3);
      repeat (3) tick();

      // Single op from requester 2: 1.0 + 2.0 = 3.0
      clear_logs();
      av[2] = 16'h3C00; bv[2] = 16'h4000; rmv[2] = 3'd0; rem[2] = 1;
      use_next = 1; next_res = 16'h4200; out_en = 0;
      tick();
      chk("single_grant", log_at(0, 0), 2);
      out_en = 1;
      tick();
      chk("single_rsp_owner", log_at(0, 1), 2);
      chk("single_rsp_result", (rsp_res_log.size() > 0) ? rsp_res_log[0] : 16'hxxxx, 16'h4200);

      // FIFO full stall
      clear_logs();
      rsp_ready_i = '0; rem[1] = 6;
      repeat (6) tick();
      chk("full_issue", grant_log.size(), 4);
      chk("full_piv", pipe_in_valid_o, 0);
      rsp_ready_i = '1;
      repeat (10) tick();
      chk("full_rsp_count", rsp_log.size(), 6);
      chk("full_grant_count", grant_log.size(), 6);
      for (int k = 0; k < 6; k++) chk("full_rsp_owner", log_at(k, 1), 1);

      // Randomized traffic
      repeat (400) begin
         pipe_in_ready_i = ($urandom_range(0, 3) != 0);
         out_en          = ($urandom_range(0, 3) != 0);
         rsp_ready_i     = NUM_REQ'($urandom);
         for (int i = 0; i < NUM_REQ; i++)
            if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 3);
         tick();
      end
      pipe_in_ready_i = 1; out_en = 1; rsp_ready_i = '1;
      repeat (30) tick();
      chk("drained", pipe_out_ready_o, 0);

      // Result with no owner
      inject_err = 1;
      tick();
      inject_err = 0;
      chk("err_set", err_o, 1);
      tick();

      // Reset in the middle of a burst
      clear_logs();
      for (int i = 0; i < NUM_REQ; i++) rem[i] = 3;
      repeat (2) tick();
      #2 rst_n = 0;
      #1;
      chk_reset_outputs("midreset");
      q.delete(); last = NUM_REQ-1; exp_err = 0; exp_issue = 0; exp_stall = 0;
      @(posedge clk); @(posedge clk); #2 rst_n = 1;
      clear_logs();
      tick();
      chk("rst_first_grant", log_at(0, 0), 0);
      repeat (20) tick();

`ifdef TC_ADD_ARB_PERF_EN
      chk("perf_issue", perf_issue_o, exp_issue);
      chk("perf_stall", perf_stall_o, exp_stall);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tc_add_arb.md
Name: tc_add_arb

Overview:
- Round-robin arbiter sharing one 2-stage tensor-core FP adder pipe between NUM_REQ requesters (e.g. dot-product reduction lanes).
- Issues one request per cycle into the pipe's valid/ready input side.
- Tags each issued op with its requester index in an in-order ID FIFO, and steers each pipe result back to the owning requester's response channel.
- Sits between the lane reduction logic and the adder pipe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, requester index width, equal to clog2(NUM_REQ).
- EXPWIDTH, 5, FP exponent width.
- PRECISION, 11, FP significand width incl. hidden bit; operand width FW = EXPWIDTH+PRECISION.
- FIFO_DEPTH, 4, max in-flight ops (power of 2, >= pipe latency 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester op valid
- req_ready_o  out  NUM_REQ  per-requester op accepted
- req_a_i  in  NUM_REQ*FW  packed operand A, requester i at [i*FW +: FW]
- req_b_i  in  NUM_REQ*FW  packed operand B
- req_rm_i  in  NUM_REQ*3  packed rounding mode
- pipe_in_valid_o  out  1  to adder pipe in_valid
- pipe_in_ready_i  in  1  from adder pipe in_ready
- pipe_a_o  out  FW  granted operand A
- pipe_b_o  out  FW  granted operand B
- pipe_rm_o  out  3  granted rounding mode
- pipe_out_valid_i  in  1  adder result valid
- pipe_out_ready_o  out  1  adder result accept
- pipe_result_i  in  FW  adder result
- pipe_fflags_i  in  5  adder fflags
- rsp_valid_o  out  NUM_REQ  one-hot response valid
- rsp_ready_i  in  NUM_REQ  per-requester response ready
- rsp_result_o  out  FW  shared response data, qualified by rsp_valid_o
- rsp_fflags_o  out  5  shared response fflags
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n low):
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - FIFO wr/rd pointers and count = 0; err_o = 0.
  - All valid/ready outputs are 0 while rst_n is low.
  - Data outputs are 0 when no grant is active.
  - A reset mid-operation drops all in-flight tags; the pipe must be reset together with this block.
- Arbitration (combinational):
  - grant = first requester with req_valid_i set, searching cyclically from ptr+1.
  - pipe_in_valid_o = |req_valid_i && !fifo_full.
  - pipe_a/b/rm_o are muxed from the granted requester.
  - req_ready_o[i] = grant[i] && pipe_in_ready_i && !fifo_full.
  - Non-granted requesters must hold their request; ready stays 0 for them.
- Issue handshake: pipe_in_valid_o && pipe_in_ready_i.
  - Push the granted index into the ID FIFO.
  - ptr <= granted index, registered next cycle.
  - The pointer does not move on a stalled cycle.
- FIFO full (count == FIFO_DEPTH): pipe_in_valid_o = 0 and all req_ready_o = 0. Push while full is never possible.
- Response routing:
  - head = FIFO[rd_ptr].
  - rsp_valid_o[head] = pipe_out_valid_i && !fifo_empty; all other bits are 0.
  - pipe_out_ready_o = rsp_ready_i[head] && !fifo_empty.
  - rsp_result_o/rsp_fflags_o pass pipe_result_i/pipe_fflags_i through combinationally.
- Pop: on pipe_out_valid_i && pipe_out_ready_o.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency:
  - Issue to pipe is 0 cycles added.
  - Result to response is 0 cycles added.
  - Throughput is 1 op/cycle when all parties are ready.
- Error: pipe_out_valid_i high while the FIFO is empty sets err_o = 1 (sticky until reset). The result is dropped, with pipe_out_ready_o = 0.

Optional Feature:
- Macro: TC_ADD_ARB_PERF_EN.
- Defined:
  - Adds output perf_issue_o[31:0], incremented on each issue handshake.
  - Adds output perf_stall_o[31:0], incremented each cycle where |req_valid_i && !(pipe_in_ready_i && !fifo_full).
  - Both counters reset to 0, saturate at 32'hFFFFFFFF, and are async-reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single op: req 2 issues a=16'h3C00, b=16'h4000, rm=0, pipe ready.
  - Requires req_ready_o=4'b0100 for 1 cycle, then pipe result 16'h4200.
  - Result must return on rsp_valid_o=4'b0100 with fflags 0.
- Round-robin: all 4 requesters hold valid for 8 cycles, all ready.
  - Grant order must be 0,1,2,3,0,1,2,3.
  - Responses must return in the same order.
- Full stall: rsp_ready_i=0, 6 requests from req 1.
  - Exactly 4 issue; pipe_in_valid_o must drop.
  - Raising rsp_ready_i must drain 4 responses to req 1, then the remaining 2 issue.
- Backpressure: pipe_in_ready_i=0 for 3 cycles with req 0 and req 3 valid.
  - Grant must stay at 0 with no pointer movement.
  - After release, order must be 0 then 3.
- Error and reset: inject pipe_out_valid_i with an empty FIFO.
  - Requires err_o=1 next cycle.
  - Assert rst_n low mid-burst: all outputs 0 and err_o=0 immediately, and the next grant must go to requester 0.
- PERF_EN build: 5 issues plus 3 stall cycles.
  - Requires perf_issue_o=5, perf_stall_o=3.
